// File: rtl/pip_cdu_count_arbiter.sv
// Serialises per-counter plus/minus pulse requests from the PIPA/CDU/optics block into one counter-increment request.
// Latency: input rising edge at cycle n, pending count at n+1, cnt_req at n+2 when idle; the next request comes 2 cycles after an ack at the earliest.
// Backpressure: while cnt_ack is low the request and its address stay frozen and new edges keep queueing; a full queue sets sticky ovf.
// Optional build macro CNT_ROUND_ROBIN_EN: rotating search start after each acked counter (default: fixed priority, index 0 first).
module pip_cdu_count_arbiter #(
    parameter int                NCNT      = 8,
    parameter int                PEND_W    = 2,
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 12'o32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              GOJAM,
    input  logic [NCNT-1:0]   inc_p,
    input  logic [NCNT-1:0]   inc_m,
    output logic              cnt_req,
    output logic [ADDR_W-1:0] cnt_addr,
    output logic              cnt_minus,
    input  logic              cnt_ack,
    output logic [NCNT-1:0]   ovf,
    input  logic              ovf_clr
);

    localparam int                IDX_W = (NCNT > 1) ? $clog2(NCNT) : 1;
    localparam logic [PEND_W-1:0] PMAX  = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Registered state
    state_t                       state_q, state_d;
    logic [NCNT-1:0]              inc_p_q, inc_p_d;
    logic [NCNT-1:0]              inc_m_q, inc_m_d;
    logic [NCNT-1:0][PEND_W-1:0]  pcnt_q, pcnt_d;
    logic [NCNT-1:0][PEND_W-1:0]  mcnt_q, mcnt_d;
    logic [NCNT-1:0]              ovf_q, ovf_d;
    logic [IDX_W-1:0]             sel_q, sel_d;
    logic [ADDR_W-1:0]            cnt_addr_q, cnt_addr_d;
    logic                         cnt_minus_q, cnt_minus_d;

    // Combinational helpers
    logic                         req_act;
    logic                         take;
    logic [NCNT-1:0]              edge_p, edge_m;
    logic [NCNT-1:0]              locked;
    logic [NCNT-1:0]              cancel;
    logic [NCNT-1:0]              dec_p, dec_m;
    logic [NCNT-1:0]              ovf_set;
    logic [NCNT-1:0][PEND_W-1:0]  peff, meff;
    logic [IDX_W-1:0]             srch_start;
    logic [IDX_W-1:0]             cand;
    logic                         sel_vld;
    logic [IDX_W-1:0]             sel_idx;
    logic                         sel_minus;

    assign req_act   = (state_q == ST_REQ);
    assign cnt_req   = req_act;
    assign cnt_addr  = cnt_addr_q;
    assign cnt_minus = cnt_minus_q;
    assign ovf       = ovf_q;

`ifdef CNT_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // Search start moves to the counter after the one just acknowledged
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (GOJAM) begin
            rr_ptr_d = '0;
        end else if (take) begin
            rr_ptr_d = (sel_q == IDX_W'(NCNT - 1)) ? '0 : sel_q + IDX_W'(1);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign srch_start = rr_ptr_q;
`else
    assign srch_start = '0;
`endif

    // Edge detect, lock mask, plus/minus cancellation and decrement sources
    always_comb begin
        take   = req_act & cnt_ack & ~GOJAM;
        edge_p = inc_p & ~inc_p_q;
        edge_m = inc_m & ~inc_m_q;
        locked = '0;
        cancel = '0;
        dec_p  = '0;
        dec_m  = '0;
        peff   = pcnt_q;
        meff   = mcnt_q;
        for (int i = 0; i < NCNT; i++) begin
            locked[i] = req_act && (sel_q == IDX_W'(i));
            // A plus and a minus on the same counter annihilate, unless the
            // counter is currently presented to the sequencer.
            cancel[i] = (pcnt_q[i] != '0) && (mcnt_q[i] != '0) && !locked[i];
            peff[i]   = pcnt_q[i] - PEND_W'(cancel[i]);
            meff[i]   = mcnt_q[i] - PEND_W'(cancel[i]);
            dec_p[i]  = cancel[i] | (take & locked[i] & ~cnt_minus_q);
            dec_m[i]  = cancel[i] | (take & locked[i] &  cnt_minus_q);
        end
    end

    // Pick the first counter with surviving work, starting at srch_start
    always_comb begin
        sel_vld   = 1'b0;
        sel_idx   = '0;
        sel_minus = 1'b0;
        cand      = '0;
        for (int k = 0; k < NCNT; k++) begin
            cand = IDX_W'((int'(srch_start) + k) % NCNT);
            if (!sel_vld && ((peff[cand] != '0) || (meff[cand] != '0))) begin
                sel_vld   = 1'b1;
                sel_idx   = cand;
                // Plus wins whenever both directions still have work
                sel_minus = (peff[cand] == '0);
            end
        end
    end

    // Pending count update with saturation, plus sticky overflow flags
    always_comb begin
        pcnt_d  = pcnt_q;
        mcnt_d  = mcnt_q;
        ovf_set = '0;
        inc_p_d = inc_p;
        inc_m_d = inc_m;
        for (int i = 0; i < NCNT; i++) begin
            // An edge and a decrement in the same cycle cancel each other out
            if (edge_p[i] && !dec_p[i]) begin
                if (pcnt_q[i] == PMAX) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    pcnt_d[i] = pcnt_q[i] + PEND_W'(1);
                end
            end else if (!edge_p[i] && dec_p[i]) begin
                pcnt_d[i] = pcnt_q[i] - PEND_W'(1);
            end

            if (edge_m[i] && !dec_m[i]) begin
                if (mcnt_q[i] == PMAX) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    mcnt_d[i] = mcnt_q[i] + PEND_W'(1);
                end
            end else if (!edge_m[i] && dec_m[i]) begin
                mcnt_d[i] = mcnt_q[i] - PEND_W'(1);
            end
        end
        // GOJAM drops all queued work; pulses arriving with it are discarded
        if (GOJAM) begin
            pcnt_d  = '0;
            mcnt_d  = '0;
            ovf_set = '0;
        end
        // A new overflow in the clear cycle must not be lost
        ovf_d = (ovf_q & ~{NCNT{ovf_clr}}) | ovf_set;
    end

    // Request handshake: idle selects and latches, request holds until ack
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_addr_d  = cnt_addr_q;
        cnt_minus_d = cnt_minus_q;
        case (state_q)
            ST_IDLE: begin
                if (!GOJAM && sel_vld) begin
                    state_d     = ST_REQ;
                    sel_d       = sel_idx;
                    cnt_addr_d  = BASE_ADDR + ADDR_W'(sel_idx);
                    cnt_minus_d = sel_minus;
                end
            end
            ST_REQ: begin
                // Dropping to idle for the cycle after an ack forms the gap
                if (GOJAM || cnt_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            inc_p_q     <= '0;
            inc_m_q     <= '0;
            pcnt_q      <= '0;
            mcnt_q      <= '0;
            ovf_q       <= '0;
            sel_q       <= '0;
            cnt_addr_q  <= '0;
            cnt_minus_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inc_p_q     <= inc_p_d;
            inc_m_q     <= inc_m_d;
            pcnt_q      <= pcnt_d;
            mcnt_q      <= mcnt_d;
            ovf_q       <= ovf_d;
            sel_q       <= sel_d;
            cnt_addr_q  <= cnt_addr_d;
            cnt_minus_q <= cnt_minus_d;
        end
    end

endmodule
